// File: rtl/mire_gen_if.sv
// Wishbone B4 write-master bundle used by the mire_gen test-pattern writer.
interface mire_gen_if;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_ms;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_ack;

    modport master (
        output wb_adr, wb_dat_ms, wb_we, wb_sel, wb_cyc, wb_stb, wb_cti, wb_bte,
        input  wb_ack
    );

    modport slave (
        input  wb_adr, wb_dat_ms, wb_we, wb_sel, wb_cyc, wb_stb, wb_cti, wb_bte,
        output wb_ack
    );
endinterface

// File: rtl/mire_gen.sv
// Framebuffer test-pattern writer: Wishbone master filling HDISP x VDISP pixels.
// Optional incrementing bursts when MIRE_GEN_BURST_EN is defined; HDISP must be >= 8.
//
// state  | meaning
// IDLE   | bus released, waiting for start
// LOAD   | latch mode/fill, rewind pixel counters
// RUN    | cyc/stb asserted, one pixel per ack
// GAP    | forced single idle cycle after THROTTLE_PERIOD beats
// DONE   | frame finished, bump frame_cnt, restart or go idle
module mire_gen #(
    parameter int          HDISP           = 800,
    parameter int          VDISP           = 480,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          THROTTLE_PERIOD = 64,
    parameter int          BURST_LEN       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  mode,
    input  logic [23:0] fill_color,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    mire_gen_if.master  wb
);
    localparam int XW = ($clog2(HDISP) < 8) ? 8 : $clog2(HDISP);
    localparam int YW = ($clog2(VDISP) < 8) ? 8 : $clog2(VDISP);
    localparam int TW = $clog2(THROTTLE_PERIOD + 1);

    localparam logic [XW-1:0] XMAX = XW'(HDISP - 1);
    localparam logic [YW-1:0] YMAX = YW'(VDISP - 1);
    localparam logic [TW-1:0] TMAX = TW'(THROTTLE_PERIOD - 1);
    localparam logic [XW+3:0] ACC0 = (XW + 4)'(HDISP);

    if (THROTTLE_PERIOD < 1 || BURST_LEN < 1) begin : g_bad_param
        $error("mire_gen: THROTTLE_PERIOD and BURST_LEN must be >= 1");
    end

`ifdef MIRE_GEN_BURST_EN
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BMAX = BW'(BURST_LEN - 1);
    localparam logic FIRST_LAST = (HDISP == 1) && (VDISP == 1);

    if ((THROTTLE_PERIOD % BURST_LEN) != 0) begin : g_bad_burst
        $error("mire_gen: THROTTLE_PERIOD must be a multiple of BURST_LEN");
    end
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state;
    logic [XW-1:0] x, nx;
    logic [YW-1:0] y, ny;
    logic [2:0]    bar, nbar;
    logic [XW+3:0] acc, nacc;
    logic          last_px;
    logic [1:0]    mode_q;
    logic [23:0]   fill_q;
    logic [TW-1:0] thr_cnt;
    logic [31:0]   adr_q;
    logic [23:0]   rgb_q;
    logic          act_q;

`ifdef MIRE_GEN_BURST_EN
    logic [BW-1:0] bcnt, bcnt_inc;
    logic [2:0]    cti_q;
    logic          nlast;
`endif

    function automatic logic [23:0] pix_rgb(
        input logic [1:0]  m,
        input logic [23:0] fill,
        input logic [7:0]  px,
        input logic [7:0]  py,
        input logic [2:0]  pbar,
        input logic [7:0]  fc
    );
        logic [7:0] s;
        logic [7:0] g;
        s = px + py;
        g = px + fc;
        pix_rgb = 24'h0;
        case (m)
            2'd0: if (px[3:0] == 4'd0 || py[3:0] == 4'd0) pix_rgb = {s, s[6:0], 1'b0, ~s};
            2'd1: begin
                case (pbar)
                    3'd0:    pix_rgb = 24'hFFFFFF;
                    3'd1:    pix_rgb = 24'hFFFF00;
                    3'd2:    pix_rgb = 24'h00FFFF;
                    3'd3:    pix_rgb = 24'h00FF00;
                    3'd4:    pix_rgb = 24'hFF00FF;
                    3'd5:    pix_rgb = 24'hFF0000;
                    3'd6:    pix_rgb = 24'h0000FF;
                    default: pix_rgb = 24'h000000;
                endcase
            end
            2'd2:    pix_rgb = {g, g, g};
            default: pix_rgb = fill;
        endcase
    endfunction

`ifdef MIRE_GEN_BURST_EN
    function automatic logic [2:0] burst_cti(
        input logic [BW-1:0] b,
        input logic [TW-1:0] t,
        input logic          lst
    );
        return (b == BMAX || t == TMAX || lst) ? 3'b111 : 3'b010;
    endfunction
`endif

    // acc holds (bar+1)*HDISP, so acc/8 is the first x of the next bar.
    always_comb begin
        last_px = (x == XMAX) && (y == YMAX);
        nx   = x + 1'b1;
        ny   = y;
        nbar = bar;
        nacc = acc;
        if (x == XMAX) begin
            nx   = '0;
            nbar = '0;
            nacc = ACC0;
            ny   = (y == YMAX) ? '0 : y + 1'b1;
        end else if ({1'b0, nx} == acc[XW+3:3]) begin
            nbar = bar + 1'b1;
            nacc = acc + ACC0;
        end
`ifdef MIRE_GEN_BURST_EN
        nlast    = (nx == XMAX) && (ny == YMAX);
        bcnt_inc = (bcnt == BMAX) ? '0 : bcnt + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            bar        <= '0;
            acc        <= ACC0;
            mode_q     <= 2'd0;
            fill_q     <= 24'h0;
            thr_cnt    <= '0;
            adr_q      <= BASE_ADDR;
            rgb_q      <= 24'h0;
            act_q      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
`ifdef MIRE_GEN_BURST_EN
            bcnt       <= '0;
            cti_q      <= 3'b000;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    mode_q  <= mode;
                    fill_q  <= fill_color;
                    x       <= '0;
                    y       <= '0;
                    bar     <= '0;
                    acc     <= ACC0;
                    thr_cnt <= '0;
                    adr_q   <= BASE_ADDR;
                    rgb_q   <= pix_rgb(mode, fill_color, 8'd0, 8'd0, 3'd0, frame_cnt);
                    act_q   <= 1'b1;
                    busy    <= 1'b1;
                    state   <= S_RUN;
`ifdef MIRE_GEN_BURST_EN
                    bcnt    <= '0;
                    cti_q   <= burst_cti('0, '0, FIRST_LAST);
`endif
                end
                S_RUN: begin
                    if (wb.wb_ack) begin
                        if (last_px) begin
                            act_q      <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= S_DONE;
`ifdef MIRE_GEN_BURST_EN
                            cti_q      <= 3'b000;
`endif
                        end else begin
                            x     <= nx;
                            y     <= ny;
                            bar   <= nbar;
                            acc   <= nacc;
                            adr_q <= adr_q + 32'd4;
                            rgb_q <= pix_rgb(mode_q, fill_q, nx[7:0], ny[7:0], nbar, frame_cnt);
                            if (thr_cnt == TMAX) begin
                                thr_cnt <= '0;
                                act_q   <= 1'b0;
                                state   <= S_GAP;
`ifdef MIRE_GEN_BURST_EN
                                bcnt    <= '0;
                                cti_q   <= burst_cti('0, '0, nlast);
`endif
                            end else begin
                                thr_cnt <= thr_cnt + 1'b1;
`ifdef MIRE_GEN_BURST_EN
                                bcnt    <= bcnt_inc;
                                cti_q   <= burst_cti(bcnt_inc, thr_cnt + 1'b1, nlast);
`endif
                            end
                        end
                    end
                end
                S_GAP: begin
                    act_q <= 1'b1;
                    state <= S_RUN;
                end
                S_DONE: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    if (continuous) begin
                        state <= S_LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wb.wb_adr    = adr_q;
    assign wb.wb_dat_ms = {8'h00, rgb_q};
    assign wb.wb_we     = 1'b1;
    assign wb.wb_sel    = 4'b1111;
    assign wb.wb_cyc    = act_q;
    assign wb.wb_stb    = act_q;
    assign wb.wb_bte    = 2'b00;
`ifdef MIRE_GEN_BURST_EN
    assign wb.wb_cti    = cti_q;
`else
    assign wb.wb_cti    = 3'b000;
`endif

endmodule

// File: tb/tb_mire_gen.sv
// Self-checking bench for mire_gen: randomized wait states against a pixel-rule reference model.
module tb_mire_gen;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int N  = H * V;
    localparam int TP = 8;
    localparam int BL = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] fill_color = 24'h0;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    mire_gen_if bus ();

    mire_gen #(
        .HDISP(H), .VDISP(V), .BASE_ADDR(BASE), .THROTTLE_PERIOD(TP), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .mode(mode), .fill_color(fill_color), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .wb(bus.master)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_fc = 0;
    logic [31:0] dlog [3*N];
    logic [23:0] fill_a, fill_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar_col(input int k);
        case (k)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [31:0] ref_pix(input logic [1:0] m, input logic [23:0] fill,
                                            input int x, input int y, input int fc);
        int s;
        int g;
        logic [7:0] sb, sb2, sn, gb;
        s   = (x + y) % 256;
        sb  = 8'(s);
        sb2 = 8'((s * 2) % 256);
        sn  = 8'(255 - s);
        g   = (x + fc) % 256;
        gb  = 8'(g);
        case (m)
            2'd0: return (x % 16 == 0 || y % 16 == 0) ? {8'h00, sb, sb2, sn} : 32'h0;
            2'd1: begin
                for (int k = 0; k < 8; k++)
                    if (x >= k * H / 8 && x < (k + 1) * H / 8) return {8'h00, bar_col(k)};
                return 32'hDEAD_BEEF;
            end
            2'd2: return {8'h00, gb, gb, gb};
            default: return {8'h00, fill};
        endcase
    endfunction

    function automatic logic [2:0] ref_cti(input int n);
`ifdef MIRE_GEN_BURST_EN
        return (((n % TP) % BL) == BL - 1 || n == N - 1) ? 3'b111 : 3'b010;
`else
        return 3'b000;
`endif
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
        chk({tag, "_cyc"}, 32'(bus.wb_cyc), 0);
        chk({tag, "_stb"}, 32'(bus.wb_stb), 0);
        chk({tag, "_cti"}, 32'(bus.wb_cti), 0);
        chk({tag, "_we"}, 32'(bus.wb_we), 1);
        chk({tag, "_sel"}, 32'(bus.wb_sel), 32'hF);
        chk({tag, "_bte"}, 32'(bus.wb_bte), 0);
    endtask

    // Acts as the Wishbone slave cycle by cycle and scores every accepted beat.
    task automatic serve(input int nframes, input int wmax, input int abort_at,
                         input int chg_frame, input int chg_at, input logic [1:0] chg_mode,
                         input logic [23:0] chg_fill, input int start_at);
        int n = 0, f = 0, cycles = 0, waits = 0, tail = 0, x, y;
        logic pend = 0, ackd = 0, gap_exp = 0, end_phase = 0, chg_done = 0, st_done = 0;
        logic [31:0] h_adr = 0, h_dat = 0;
        logic [2:0]  h_cti = 0;
        logic [1:0]  c_mode;
        logic [23:0] c_fill;
        int          c_fc;
        c_mode = mode;
        c_fill = fill_color;
        c_fc   = exp_fc;
        while (1) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            bus.wb_ack = 1'b0;
            if (cycles > 4000) begin
                n_cmp++;
                n_bad++;
                $error("FAIL timeout observed_beats=%0d frame=%0d", n, f);
                break;
            end
            if (end_phase) begin
                tail++;
                chk("idle_stb", 32'(bus.wb_stb), 0);
                if (tail == 1) begin
                    chk("idle_busy", 32'(busy), 0);
                    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
                end
                if (tail == 4) break;
                continue;
            end
            if (ackd) begin
                ackd = 0;
                x = n % H;
                y = n / H;
                chk("adr", h_adr, BASE + 32'((y * H + x) * 4));
                chk("dat", h_dat, ref_pix(c_mode, c_fill, x, y, c_fc));
                chk("cti", 32'(h_cti), 32'(ref_cti(n)));
                if (f < 3) dlog[f * N + n] = h_dat;
                n++;
                chk("stb_after_ack", 32'(bus.wb_stb), (n == N || n % TP == 0) ? 0 : 1);
                chk("cyc_after_ack", 32'(bus.wb_cyc), (n == N || n % TP == 0) ? 0 : 1);
                chk("frame_done", 32'(frame_done), 32'(n == N));
                gap_exp = (n % TP == 0) && (n < N);
                if (n == N) begin
                    chk("busy_in_done", 32'(busy), 1);
                    exp_fc = (exp_fc + 1) % 256;
                    f++;
                    n = 0;
                    if (f == nframes) begin
                        end_phase = 1;
                        continue;
                    end
                    c_mode = mode;
                    c_fill = fill_color;
                    c_fc   = exp_fc;
                end
            end else begin
                if (gap_exp) chk("stb_after_gap", 32'(bus.wb_stb), 1);
                gap_exp = 0;
                chk("frame_done_low", 32'(frame_done), 0);
            end
            if (abort_at >= 0 && f == 0 && n == abort_at && bus.wb_stb) begin
                rst_n = 1'b0;
                #1;
                chk("abort_cyc", 32'(bus.wb_cyc), 0);
                chk("abort_stb", 32'(bus.wb_stb), 0);
                return;
            end
            if (!chg_done && f == chg_frame && n == chg_at) begin
                mode = chg_mode;
                fill_color = chg_fill;
                chg_done = 1;
            end
            if (!st_done && start_at >= 0 && f == 0 && n == start_at) begin
                start = 1'b1;
                st_done = 1;
            end
            if (continuous && f == nframes - 1 && n == N / 2) continuous = 1'b0;
            if (bus.wb_stb) begin
                if (!pend) begin
                    pend  = 1;
                    h_adr = bus.wb_adr;
                    h_dat = bus.wb_dat_ms;
                    h_cti = bus.wb_cti;
                    waits = int'($urandom_range(wmax, 0));
                end else begin
                    chk("adr_hold", bus.wb_adr, h_adr);
                    chk("dat_hold", bus.wb_dat_ms, h_dat);
                    chk("cti_hold", 32'(bus.wb_cti), 32'(h_cti));
                end
                if (waits == 0) begin
                    bus.wb_ack = 1'b1;
                    ackd = 1;
                    pend = 0;
                end else begin
                    waits--;
                end
            end else if (pend) begin
                chk("stb_hold", 32'(bus.wb_stb), 1);
                pend = 0;
            end
        end
        bus.wb_ack = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        bus.wb_ack = 1'b0;
        fill_a = 24'($urandom);
        fill_b = 24'($urandom);
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", 32'(bus.wb_stb), 0);

        // grid, zero-wait slave
        mode = 2'd0;
        pulse_start();
        serve(1, 0, -1, -1, 0, 2'd0, 24'h0, -1);
        chk("grid_px00", dlog[0], 32'h0000_00FF);
        chk("grid_px51", dlog[1 * H + 5], 32'h0000_0000);

        // colour bars with waits; mode switched mid-frame must not take effect
        mode = 2'd1;
        pulse_start();
        serve(1, 5, -1, 0, 30, 2'd0, 24'h0, -1);
        chk("bar_x0", dlog[0], 32'h00FF_FFFF);
        chk("bar_x1", dlog[1], 32'h00FF_FFFF);
        chk("bar_x2", dlog[2], 32'h00FF_FF00);
        chk("bar_x15", dlog[15], 32'h0000_0000);
        chk("bar_row3_x15", dlog[3 * H + 15], 32'h0000_0000);

        // solid fill; start while busy and fill change mid-frame ignored
        mode = 2'd3;
        fill_color = fill_a;
        pulse_start();
        serve(1, 3, -1, 0, 40, 2'd3, fill_b, 10);
        chk("solid_last", dlog[N - 1], {8'h00, fill_a});

        // async reset at pixel 20
        mode = 2'd0;
        pulse_start();
        serve(1, 2, 20, -1, 0, 2'd0, 24'h0, -1);
        check_reset("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_fc = 0;
        repeat (5) @(negedge clk);
        chk("post_rst_stb", 32'(bus.wb_stb), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // continuous gradient, then switch to solid for the third frame
        mode = 2'd2;
        continuous = 1'b1;
        pulse_start();
        serve(3, 2, -1, 1, 20, 2'd3, fill_b, -1);
        chk("grad_f0_px00", dlog[0], 32'h0000_0000);
        chk("grad_f1_px00", dlog[N], 32'h0001_0101);
        chk("grad_f1_px5", dlog[N + 5], 32'h0006_0606);
        chk("solid_f2_px00", dlog[2 * N], {8'h00, fill_b});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
